quad_decoder: RTL and testbench
===============================

// Module: quad_decoder
// PURPOSE
//   Quadrature-encoder front end that generates the up/ena step controls for the
//   3-bit up/down counter in the counters block.
//   Synchronises raw A/B phase inputs, optionally deglitches them, decodes the
//   Gray-code phase sequence into one-cycle count pulses with direction, and
//   flags/counts illegal phase jumps.
// PARAMETERS
//   SYNC_STAGES  2   flops in each A/B input synchroniser chain (legal: 2..4)
//   RES          4   steps per Gray cycle: 1, 2 or 4 (other values illegal)
//   FILT_LEN     4   consecutive equal samples needed to accept a new level (filter only, 2..16)
// PORTS
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   a_in     in   1   encoder phase A, asynchronous to clk
//   b_in     in   1   encoder phase B, asynchronous to clk
//   ena      out  1   one-cycle step strobe to the counter
//   up       out  1   step direction: 1 = increment; valid with ena, holds last value otherwise
//   err      out  1   one-cycle strobe on an illegal transition (A and B change together)
//   err_cnt  out  8   illegal-transition count, saturating at 8'hFF
// BEHAVIOUR
//   - Reset, asynchronous: all sync/filter flops, ena, up, err = 0; err_cnt = 0; primed = 0.
//   - Sync: a_in and b_in each pass through SYNC_STAGES flops, giving a_s and b_s.
//   - Decode state: prev = {a,b} from the previous accepted sample.
//     - First cycle after reset release, and every cycle until primed = 1:
//       - prev loads the current {a,b}.
//       - primed goes to 1.
//       - No ena and no err is produced.
//   - Forward sequence 00->01->11->10->00 produces up = 1.
//     Reverse sequence 00->10->11->01->00 produces up = 0.
//   - No change: ena = 0, err = 0.
//   - Both bits change, e.g. 00->11: err = 1 for one cycle; ena = 0; up unchanged;
//     prev updates to the new value; err_cnt increments unless it already equals 8'hFF.
//   - RES gating applies to legal transitions only:
//     - RES = 4: every legal transition produces a step.
//     - RES = 2: only transitions into 00 or 11 produce a step.
//     - RES = 1: only transitions into 00 produce a step.
//     - Gated-out legal transitions update prev silently.
//   - ena, up and err are registered.
//     - Latency: 1 clk from the sample in which the decoder sees the new {a,b}.
//     - Without the filter: SYNC_STAGES+1 clks from the a_in/b_in edge to ena.
//   - ena and err are never high in the same cycle.
//     At most one step per clk; input rates above clk/(SYNC_STAGES+1) are unsupported.
//   - up changes only in a cycle where ena = 1.
//   - Reset asserted mid-sequence: outputs clear immediately.
//     After release the block re-primes, so no spurious step or err occurs.
// CONFIGURATION
//   QDEC_GLITCH_FILTER_EN defined:
//     - Each synchronised phase passes through a stable-count filter.
//     - The filter output changes only after FILT_LEN consecutive clks of the new level.
//     - A counter of ceil(log2(FILT_LEN+1)) bits per phase resets whenever the sample
//       equals the current filtered level.
//     - Filter outputs reset to 0.
//     - Added latency: FILT_LEN clks.
//   QDEC_GLITCH_FILTER_EN undefined:
//     - The decoder uses a_s/b_s directly.
//     - No filter logic is present.
//     - FILT_LEN is ignored.
// TESTING
//   - Reset release with A=B=1 held: no ena and no err for 20 clks; prev = 11.
//   - RES=4, forward cycle 00,01,11,10,00 (8 clks per step): 4 ena pulses with up=1;
//     downstream counter reads 3'd4.
//   - RES=4, reverse 2 full cycles: 8 ena pulses with up=0; counter wraps from 0 to 3'd0
//     through 7..1.
//   - RES=1, forward 3 full cycles: exactly 3 ena pulses, each on entry to 00.
//   - Jump 00->11, repeated 300 times alternating 00/11: err pulses each time, ena never
//     asserts, err_cnt stops at 8'hFF.
//   - QDEC_GLITCH_FILTER_EN with FILT_LEN=4: a 3-clk A glitch gives no ena; a 4-clk
//     stable edge gives ena at SYNC_STAGES+4+1 clks. Reset mid-cycle clears err_cnt and ena.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises A/B, optionally deglitches them, and decodes
// Gray-code phase steps into registered ena/up strobes plus illegal-jump err/err_cnt.
// Optional stable-count glitch filter is built when QDEC_GLITCH_FILTER_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_PRIME | pipeline still filling after reset; prev follows cur, no strobes
//   ST_TRACK | prev holds last accepted phase; transitions decoded every clk
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int RES         = 4,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       ena,
    output logic       up,
    output logic       err,
    output logic [7:0] err_cnt
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("quad_decoder: SYNC_STAGES must be 2..4");
    end
    if (RES != 1 && RES != 2 && RES != 4) begin : g_bad_res
        $error("quad_decoder: RES must be 1, 2 or 4");
    end

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Stay in priming until the phase seen by the decoder reflects the pins,
    // otherwise the sync/filter flush after reset would look like a jump.
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int PRIME_LAST = SYNC_STAGES + 1;
`else
    localparam int PRIME_LAST = SYNC_STAGES;
`endif
    localparam int PC_W = $clog2(PRIME_LAST + 1);
    localparam logic [PC_W-1:0] PRIME_LAST_C = PC_W'(PRIME_LAST);

    state_t                 state;
    state_t                 state_d;
    logic [PC_W-1:0]        prime_cnt;
    logic [PC_W-1:0]        prime_cnt_d;
    logic [1:0]             prev;
    logic [1:0]             prev_d;
    logic [1:0]             cur;
    logic                   ena_d;
    logic                   up_d;
    logic                   err_d;
    logic [7:0]             err_cnt_d;

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_s;
    logic                   b_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    assign a_s = a_sync[SYNC_STAGES-1];
    assign b_s = b_sync[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
    if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_bad_filt
        $error("quad_decoder: FILT_LEN must be 2..16");
    end

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [1:0]       ph_s;
    logic [1:0]       ph_f;
    logic [CNT_W-1:0] flt_cnt [2];

    assign ph_s = {a_s, b_s};

    // A new level is accepted on the FILT_LEN-th consecutive differing sample.
    // While priming the filter follows its input so it starts from the pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_f <= '0;
            for (int i = 0; i < 2; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state == ST_PRIME) begin
                    ph_f[i]    <= ph_s[i];
                    flt_cnt[i] <= '0;
                end else if (ph_s[i] == ph_f[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CNT_LAST) begin
                    ph_f[i]    <= ph_s[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cur = ph_f;
`else
    assign cur = {a_s, b_s};
`endif

    // Gray phase to position: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [1:0] pos_fwd;
    logic       fwd;
    logic       jump;
    logic       step_ok;

    assign pos_fwd = gray_pos(prev) + 2'd1;
    assign fwd     = (gray_pos(cur) == pos_fwd);
    assign jump    = &(cur ^ prev);

    always_comb begin
        step_ok = 1'b1;
        if (RES == 2) begin
            step_ok = (cur[1] == cur[0]);
        end else if (RES == 1) begin
            step_ok = (cur == 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
            prev      <= 2'b00;
            ena       <= 1'b0;
            up        <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_d;
            prime_cnt <= prime_cnt_d;
            prev      <= prev_d;
            ena       <= ena_d;
            up        <= up_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        prime_cnt_d = prime_cnt;
        prev_d      = prev;
        ena_d       = 1'b0;
        up_d        = up;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt;
        case (state)
            ST_PRIME: begin
                prev_d = cur;
                if (prime_cnt == PRIME_LAST_C) begin
                    state_d = ST_TRACK;
                end else begin
                    prime_cnt_d = prime_cnt + 1'b1;
                end
            end
            ST_TRACK: begin
                if (cur != prev) begin
                    prev_d = cur;
                    if (jump) begin
                        err_d = 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt_d = err_cnt + 8'd1;
                        end
                    end else if (step_ok) begin
                        ena_d = 1'b1;
                        up_d  = fwd;
                    end
                end
            end
            default: state_d = ST_PRIME;
        endcase
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: three instances (RES 4/2/1) share the A/B stimulus,
// a negedge monitor models the downstream 3-bit counter and counts strobes.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       ena4, up4, err4;
    logic       ena2, up2, err2;
    logic       ena1, up1, err1;
    logic [7:0] ecnt4, ecnt2, ecnt1;

    always #5 clk = ~clk;

    quad_decoder #(.SYNC_STAGES(2), .RES(4), .FILT_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .ena(ena4), .up(up4), .err(err4), .err_cnt(ecnt4));
    quad_decoder #(.SYNC_STAGES(2), .RES(2), .FILT_LEN(4)) dut2 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .ena(ena2), .up(up2), .err(err2), .err_cnt(ecnt2));
    quad_decoder #(.SYNC_STAGES(2), .RES(1), .FILT_LEN(4)) dut1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .ena(ena1), .up(up1), .err(err1), .err_cnt(ecnt1));

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int EXP_LAT = 2 + 4 + 1;
`else
    localparam int EXP_LAT = 2 + 1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: downstream counter model plus strobe bookkeeping.
    int       ena4_tot = 0, ena2_tot = 0, ena1_tot = 0;
    int       err4_tot = 0, err1_tot = 0;
    int       overlap = 0, up_glitch = 0, bad1 = 0, bad2 = 0;
    logic [2:0] ctr = 3'd0;
    logic     up4_q = 1'b0;

    always @(negedge clk) begin
        if (ena4) begin
            ena4_tot++;
            ctr = up4 ? ctr + 3'd1 : ctr - 3'd1;
        end
        if (ena2) begin
            ena2_tot++;
            if (a_in != b_in) bad2++;
        end
        if (ena1) begin
            ena1_tot++;
            if ({a_in, b_in} != 2'b00) bad1++;
        end
        if (err4) err4_tot++;
        if (err1) err1_tot++;
        if ((ena4 && err4) || (ena2 && err2) || (ena1 && err1)) overlap++;
        if (!rst && (up4 != up4_q) && !ena4) up_glitch++;
        up4_q = up4;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int hold);
        {a_in, b_in} = v;
        tick(hold);
    endtask

    initial begin
        int         b4, b2, b1, be4, be1;
        logic [2:0] cb;
        logic [2:0] cd;
        int         lat;

        rst  = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        tick(3);
        check("rst_ena", ena4, 0);
        check("rst_err", err4, 0);
        check("rst_up", up4, 0);
        check("rst_errcnt", ecnt4, 0);

        // Release with A=B=1 held: must prime to 11 without strobes.
        rst = 1'b0;
        tick(20);
        check("prime_ena", ena4_tot + ena2_tot + ena1_tot, 0);
        check("prime_err", err4_tot + err1_tot, 0);
        check("prime_prev", dut4.prev, 2'b11);

        rst = 1'b1;
        {a_in, b_in} = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(10);

        // Forward one cycle.
        b4 = ena4_tot; b2 = ena2_tot; b1 = ena1_tot; be4 = err4_tot; cb = ctr;
        drive(2'b01, 8);
        drive(2'b11, 8);
        drive(2'b10, 8);
        drive(2'b00, 8);
        cd = ctr - cb;
        check("fwd_ena4", ena4_tot - b4, 4);
        check("fwd_ctr", cd, 4);
        check("fwd_up", up4, 1);
        check("fwd_ena2", ena2_tot - b2, 2);
        check("fwd_ena1", ena1_tot - b1, 1);
        check("fwd_err", err4_tot - be4, 0);

        // Reverse two cycles, counter wraps 0 -> 7 .. 1 -> 0.
        b4 = ena4_tot; b2 = ena2_tot; b1 = ena1_tot; cb = ctr;
        drive(2'b10, 8);
        cd = ctr - cb;
        check("rev_wrap7", cd, 7);
        drive(2'b11, 8);
        drive(2'b01, 8);
        drive(2'b00, 8);
        drive(2'b10, 8);
        drive(2'b11, 8);
        drive(2'b01, 8);
        drive(2'b00, 8);
        cd = ctr - cb;
        check("rev_ena4", ena4_tot - b4, 8);
        check("rev_ctr", cd, 0);
        check("rev_up", up4, 0);
        check("rev_ena2", ena2_tot - b2, 4);
        check("rev_ena1", ena1_tot - b1, 2);

        // RES=1 forward three cycles.
        b4 = ena4_tot; b2 = ena2_tot; b1 = ena1_tot;
        for (int c = 0; c < 3; c++) begin
            drive(2'b01, 8);
            drive(2'b11, 8);
            drive(2'b10, 8);
            drive(2'b00, 8);
        end
        check("res1_ena", ena1_tot - b1, 3);
        check("res1_up", up1, 1);
        check("res1_on00", bad1, 0);
        check("res2_ena", ena2_tot - b2, 6);
        check("res2_on00_11", bad2, 0);
        check("res4_ena", ena4_tot - b4, 12);

        // 300 alternating jumps 00 <-> 11.
        b4 = ena4_tot; b1 = ena1_tot; be4 = err4_tot; be1 = err1_tot;
        for (int j = 0; j < 300; j++) begin
            drive((j % 2 == 0) ? 2'b11 : 2'b00, 4);
        end
        tick(4);
        check("jump_err4", err4_tot - be4, 300);
        check("jump_err1", err1_tot - be1, 300);
        check("jump_ena4", ena4_tot - b4, 0);
        check("jump_ena1", ena1_tot - b1, 0);
        check("jump_sat4", ecnt4, 8'hFF);
        check("jump_sat1", ecnt1, 8'hFF);
        check("jump_up", up4, 1);

        // Pin edge to ena latency.
        lat = 0;
        {a_in, b_in} = 2'b01;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ena4) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, EXP_LAT);
        check("lat_up", up4, 1);
        tick(10);

`ifdef QDEC_GLITCH_FILTER_EN
        b4 = ena4_tot; be4 = err4_tot;
        a_in = 1'b1;
        tick(3);
        a_in = 1'b0;
        tick(12);
        check("glitch_ena", ena4_tot - b4, 0);
        check("glitch_err", err4_tot - be4, 0);
`endif

        // Reset while ena is high.
        lat = 0;
        {a_in, b_in} = 2'b11;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ena4) begin
                lat = n;
                break;
            end
        end
        check("mid_seen", lat, EXP_LAT);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ena", ena4, 0);
        check("mid_errcnt", ecnt4, 0);
        check("mid_up", up4, 0);
        tick(3);
        rst = 1'b0;
        b4 = ena4_tot; b2 = ena2_tot; b1 = ena1_tot; be4 = err4_tot; be1 = err1_tot;
        tick(20);
        check("reprime_ena", (ena4_tot - b4) + (ena2_tot - b2) + (ena1_tot - b1), 0);
        check("reprime_err", (err4_tot - be4) + (err1_tot - be1), 0);
        check("reprime_prev", dut4.prev, 2'b11);

        check("no_overlap", overlap, 0);
        check("up_only_on_ena", up_glitch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
